// File: rtl/spi_flash_ctrl_v2.sv
// SPI mode-0 flash controller for the 6809 bus: byte reads (READ 0x03) and byte writes
// (WREN, PAGE PROGRAM, RDSR polling), holding o_ready low for the whole transaction.
module spi_flash_ctrl_v2 #(
  parameter int          CLK_DIV    = 1,
  parameter int          ADDR_BITS  = 12,
  parameter logic [23:0] ADDR_BASE  = 24'h000000,
  parameter int          CS_GAP     = 2,
  parameter int          POLL_LIMIT = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_ce,
  input  logic        i_rw,
  input  logic [15:0] i_addr,
  input  logic [7:0]  i_data,
  input  logic        i_miso,
  output logic        o_sclk,
  output logic        o_mosi,
  output logic        o_cs_n,
  output logic [7:0]  o_data,
  output logic        o_ready,
  output logic        o_err
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_XFER,
    ST_WREN,
    ST_GAP,
    ST_PROG,
    ST_POLL
  } state_t;

  localparam logic [15:0] DIV_RELOAD = 16'(CLK_DIV - 1);
  localparam logic [15:0] GAP_RELOAD = 16'(CS_GAP - 1);
  localparam logic [15:0] POLL_MAX   = 16'(POLL_LIMIT);

  state_t      state_q, state_d;
  state_t      nxt_q, nxt_d;
  logic        sclk_q, sclk_d;
  logic        mosi_q, mosi_d;
  logic        cs_n_q, cs_n_d;
  logic [7:0]  data_q, data_d;
  logic        ready_q, ready_d;
  logic        err_q, err_d;
  logic        armed_q, armed_d;
  logic [23:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [39:0] shift_q, shift_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] div_q, div_d;
  logic [15:0] gap_q, gap_d;
  logic [7:0]  rx_q, rx_d;
  logic [15:0] poll_cnt_q, poll_cnt_d;

  logic [23:0] addr_lo;
  logic [23:0] flash_addr;
  logic [15:0] poll_inc;
  logic        start;
  logic [39:0] load_word;
  logic [5:0]  load_cnt;
  logic        unused_addr;

  assign unused_addr = ^i_addr;

  always_comb begin
    addr_lo = '0;
    addr_lo[ADDR_BITS-1:0] = i_addr[ADDR_BITS-1:0];
    flash_addr = ADDR_BASE | addr_lo;
  end

  assign poll_inc = (poll_cnt_q == '1) ? poll_cnt_q : poll_cnt_q + 16'd1;

  always_comb begin
    state_d    = state_q;
    nxt_d      = nxt_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    cs_n_d     = cs_n_q;
    data_d     = data_q;
    ready_d    = ready_q;
    err_d      = err_q;
    armed_d    = armed_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    div_d      = div_q;
    gap_d      = gap_q;
    rx_d       = rx_q;
    poll_cnt_d = poll_cnt_q;
    start      = 1'b0;
    load_word  = '0;
    load_cnt   = '0;

    // Re-arming only happens while CE is low, so a held CE cannot retrigger.
    if (!i_ce) armed_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (i_ce && armed_q) begin
          armed_d    = 1'b0;
          ready_d    = 1'b0;
          err_d      = 1'b0;
          addr_d     = flash_addr;
          wdata_d    = i_data;
          poll_cnt_d = '0;
          start      = 1'b1;
          if (i_rw) begin
            state_d   = ST_RD_XFER;
            load_word = {8'h03, flash_addr, 8'h00};
            load_cnt  = 6'd39;
          end else begin
            state_d   = ST_WREN;
            load_word = {8'h06, 32'h0};
            load_cnt  = 6'd7;
          end
        end
      end

      ST_GAP: begin
        if (gap_q == '0) begin
          start   = 1'b1;
          state_d = nxt_q;
          if (nxt_q == ST_PROG) begin
            load_word = {8'h02, addr_q, wdata_q};
            load_cnt  = 6'd39;
          end else begin
            load_word = {8'h05, 32'h0};
            load_cnt  = 6'd15;
          end
        end else begin
          gap_d = gap_q - 16'd1;
        end
      end

      default: begin
        // Active burst: low phase then high phase per bit, each CLK_DIV clocks long.
        if (div_q != '0) begin
          div_d = div_q - 16'd1;
        end else if (!sclk_q) begin
          sclk_d = 1'b1;
          div_d  = DIV_RELOAD;
          rx_d   = {rx_q[6:0], i_miso};
        end else if (bit_cnt_q != '0) begin
          sclk_d    = 1'b0;
          mosi_d    = shift_q[39];
          shift_d   = {shift_q[38:0], 1'b0};
          bit_cnt_d = bit_cnt_q - 6'd1;
          div_d     = DIV_RELOAD;
        end else begin
          sclk_d = 1'b0;
          cs_n_d = 1'b1;
          mosi_d = 1'b0;
          case (state_q)
            ST_RD_XFER: begin
              data_d  = rx_q;
              ready_d = 1'b1;
              state_d = ST_IDLE;
            end
            ST_WREN: begin
              state_d = ST_GAP;
              nxt_d   = ST_PROG;
              gap_d   = GAP_RELOAD;
            end
            ST_PROG: begin
              state_d = ST_GAP;
              nxt_d   = ST_POLL;
              gap_d   = GAP_RELOAD;
            end
            default: begin
              poll_cnt_d = poll_inc;
              if (!rx_q[0]) begin
                ready_d = 1'b1;
                state_d = ST_IDLE;
              end else if (poll_inc >= POLL_MAX) begin
                err_d   = 1'b1;
                ready_d = 1'b1;
                state_d = ST_IDLE;
              end else begin
                state_d = ST_GAP;
                nxt_d   = ST_POLL;
                gap_d   = GAP_RELOAD;
              end
            end
          endcase
        end
      end
    endcase

    // CS falls with the first MOSI bit, one half-period before the first SCLK rise.
    if (start) begin
      cs_n_d    = 1'b0;
      sclk_d    = 1'b0;
      mosi_d    = load_word[39];
      shift_d   = {load_word[38:0], 1'b0};
      bit_cnt_d = load_cnt;
      div_d     = DIV_RELOAD;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      nxt_q      <= ST_PROG;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      data_q     <= '0;
      ready_q    <= 1'b1;
      err_q      <= 1'b0;
      armed_q    <= 1'b1;
      addr_q     <= '0;
      wdata_q    <= '0;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      div_q      <= '0;
      gap_q      <= '0;
      rx_q       <= '0;
      poll_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      nxt_q      <= nxt_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      cs_n_q     <= cs_n_d;
      data_q     <= data_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
      armed_q    <= armed_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      div_q      <= div_d;
      gap_q      <= gap_d;
      rx_q       <= rx_d;
      poll_cnt_q <= poll_cnt_d;
    end
  end

  assign o_sclk  = sclk_q;
  assign o_mosi  = mosi_q;
  assign o_cs_n  = cs_n_q;
  assign o_data  = data_q;
  assign o_ready = ready_q;
  assign o_err   = err_q;

endmodule
